// File: rtl/sprite_row_reader.sv
// Sprite row reader: fetches one sprite row per scanline from a
// registered-address ROM, buffers it and renders it against the pixel stream.
// Ports: clk, rst (async, active-high); line_start/line_y/sprite_x/sprite_y
// start a line; pix_valid/pix_x pixel stream; rom_addr/rom_data ROM side;
// pixel_on/pixel_out_valid registered pixel result; busy while fetching.
module sprite_row_reader #(
  parameter int WIDTH  = 51,
  parameter int HEIGHT = 60,
  parameter int ADDR_W = 6,
  parameter int X_W    = 11,
  parameter int Y_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [Y_W-1:0]    line_y,
  input  logic [X_W-1:0]    sprite_x,
  input  logic [Y_W-1:0]    sprite_y,
  input  logic              pix_valid,
  input  logic [X_W-1:0]    pix_x,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              pixel_on,
  output logic              pixel_out_valid,
  output logic              busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [Y_W:0] HLIM = (Y_W+1)'(HEIGHT);
  localparam logic [X_W:0] WLIM = (X_W+1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } state_t;

  state_t state, state_nx;

  logic [X_W-1:0]   x_lat;
  logic [WIDTH-1:0] row_buf;
  logic             row_valid;

  // Row offset with a borrow bit: row[Y_W] set means line above sprite.
  logic [Y_W:0] row;
  logic         row_ok;

  assign row    = {1'b0, line_y} - {1'b0, sprite_y};
  assign row_ok = !row[Y_W] && (row < HLIM);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A new line overrides any fetch in flight.
    if (line_start)
      state_nx = row_ok ? ISSUE : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_lat     <= '0;
      rom_addr  <= '0;
      row_buf   <= '0;
      row_valid <= 1'b0;
    end else begin
      if (line_start) begin
        x_lat     <= sprite_x;
        row_valid <= 1'b0;
        if (row_ok)
          rom_addr <= row[ADDR_W-1:0];
      end else if (state == CAPTURE) begin
        row_buf   <= rom_data;
        row_valid <= 1'b1;
      end
    end
  end

  // Pixel path: dx with borrow so columns left of the sprite never wrap.
  logic [X_W:0]     dx;
  logic [CW-1:0]    col;
  logic [WIDTH-1:0] shifted;
  logic             hit;

  assign dx      = {1'b0, pix_x} - {1'b0, x_lat};
  assign col     = dx[CW-1:0];
  assign shifted = row_buf << col;
  assign hit     = pix_valid && row_valid && !dx[X_W] &&
                   (dx < WLIM) && shifted[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_on        <= 1'b0;
      pixel_out_valid <= 1'b0;
    end else begin
      pixel_on        <= hit;
      pixel_out_valid <= pix_valid;
    end
  end

endmodule

// File: tb/tb_sprite_row_reader.sv
// Self-checking bench for sprite_row_reader with a two-stage ROM model.
// Table-driven pixel vectors plus directed fetch/abort/reset sequences.
module tb_sprite_row_reader;

  localparam int WIDTH = 51;
  localparam int HEIGHT = 60;

  logic        clk = 0;
  logic        rst;
  logic        line_start;
  logic [9:0]  line_y;
  logic [10:0] sprite_x;
  logic [9:0]  sprite_y;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [5:0]  rom_addr;
  logic [50:0] rom_data;
  logic        pixel_on;
  logic        pixel_out_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_row_reader dut (
    .clk(clk), .rst(rst),
    .line_start(line_start), .line_y(line_y),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .pix_valid(pix_valid), .pix_x(pix_x),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_on(pixel_on), .pixel_out_valid(pixel_out_valid),
    .busy(busy)
  );

  // ROM contents used by the tests
  function automatic logic [50:0] rom_row(input logic [5:0] r);
    logic [50:0] v;
    case (r)
      6'd0:  v = 51'd1 << 26;
      6'd10: v = {51{1'b1}};
      6'd15: v = {51{1'b1}};
      6'd20: v = {51{1'b1}};
      6'd45: v = {1'b0, {49{1'b1}}, 1'b0};
      default: v = 51'h5;
    endcase
    return v;
  endfunction

  // Address register then data register: data valid 2 cycles after addr.
  logic [5:0]  addr_q;
  always_ff @(posedge clk) begin
    addr_q   <= rom_addr;
    rom_data <= rom_row(addr_q);
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (rom_addr >= 6'(HEIGHT)) begin
        errors++;
        $display("FAIL rom_addr_range got %0d need < %0d", rom_addr, HEIGHT);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          grp;
    logic        v;
    logic [10:0] x;
    logic        on;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int g, input logic v, input logic [10:0] x,
                     input logic on);
    vec_t e;
    e.grp = g; e.v = v; e.x = x; e.on = on;
    vecs.push_back(e);
  endtask

  task automatic run_grp(input int g);
    foreach (vecs[i]) begin
      if (vecs[i].grp == g) begin
        pix_valid = vecs[i].v;
        pix_x = vecs[i].x;
        tick();
        chk($sformatf("g%0d_on_x%0d", g, vecs[i].x), 32'(pixel_on),
            32'(vecs[i].on));
        chk($sformatf("g%0d_pov_x%0d", g, vecs[i].x),
            32'(pixel_out_valid), 32'(vecs[i].v));
      end
    end
    pix_valid = 0;
  endtask

  task automatic start_line(input logic [9:0] y);
    line_y = y;
    line_start = 1;
    tick();
    line_start = 0;
  endtask

  // Full fetch: addr visible after pulse, busy exactly 3 cycles.
  task automatic fetch(input logic [9:0] y, input logic [5:0] a);
    start_line(y);
    chk("fetch_addr", 32'(rom_addr), 32'(a));
    chk("busy_c1", 32'(busy), 1);
    tick();
    chk("busy_c2", 32'(busy), 1);
    tick();
    chk("busy_c3", 32'(busy), 1);
    tick();
    chk("busy_done", 32'(busy), 0);
  endtask

  task automatic sweep_off(input string name, input int lo, input int hi);
    for (int x = lo; x <= hi; x++) begin
      pix_valid = 1;
      pix_x = 11'(x);
      tick();
      chk(name, 32'(pixel_on), 0);
    end
    pix_valid = 0;
  endtask

  initial begin
    // group 2: row 0, single pixel at column 24
    add(2, 1, 11'd123, 0);
    add(2, 1, 11'd124, 1);
    add(2, 1, 11'd125, 0);
    add(2, 0, 11'd124, 0);
    // group 3: row 15, full row
    add(3, 1, 11'd99, 0);
    for (int x = 100; x <= 150; x++) add(3, 1, 11'(x), 1);
    add(3, 1, 11'd151, 0);
    // group 5: row 45, edges dark
    add(5, 1, 11'd100, 0);
    add(5, 1, 11'd101, 1);
    add(5, 1, 11'd149, 1);
    add(5, 1, 11'd150, 0);
    // group 6: sprite at right edge, no wrap
    for (int x = 2000; x <= 2047; x++) add(6, 1, 11'(x), 1);
    for (int x = 0; x <= 50; x++) add(6, 1, 11'(x), 0);
    add(6, 0, 11'd2010, 0);
    add(6, 0, 11'd5, 0);

    rst = 1; line_start = 0; line_y = 0; sprite_x = 0; sprite_y = 0;
    pix_valid = 0; pix_x = 0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_on", 32'(pixel_on), 0);
    chk("rst_pov", 32'(pixel_out_valid), 0);
    rst = 0;
    tick();

    // 1: reset during WAIT
    sprite_x = 100; sprite_y = 200;
    start_line(10'd210);
    chk("t1_addr", 32'(rom_addr), 10);
    tick();
    chk("t1_wait_busy", 32'(busy), 1);
    #2 rst = 1;
    tick();
    chk("t1_busy", 32'(busy), 0);
    chk("t1_addr0", 32'(rom_addr), 0);
    chk("t1_on", 32'(pixel_on), 0);
    chk("t1_pov", 32'(pixel_out_valid), 0);
    rst = 0;
    tick();
    sweep_off("t1_burst", 0, 160);
    tick(); tick();

    // 2: row 0
    fetch(10'd200, 6'd0);
    run_grp(2);

    // 3: row 15
    fetch(10'd215, 6'd15);
    run_grp(3);

    // 4: out-of-range lines (above, and exactly HEIGHT below)
    start_line(10'd199);
    chk("t4a_busy", 32'(busy), 0);
    chk("t4a_addr", 32'(rom_addr), 15);
    sweep_off("t4a_off", 0, 2047);
    start_line(10'd260);
    chk("t4b_busy", 32'(busy), 0);
    chk("t4b_addr", 32'(rom_addr), 15);
    sweep_off("t4b_off", 0, 2047);

    // 5: abort during WAIT
    start_line(10'd210);
    chk("t5_addr10", 32'(rom_addr), 10);
    tick();
    chk("t5_wait", 32'(busy), 1);
    sprite_x = 100;
    fetch(10'd245, 6'd45);
    run_grp(5);

    // 6: sprite near right edge; later sprite_x change must not matter
    sprite_x = 2000; sprite_y = 300;
    fetch(10'd320, 6'd20);
    sprite_x = 0; sprite_y = 0;
    run_grp(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_row_reader.md
Name: sprite_row_reader

Overview:
- Consumer side of the registered-address sprite ROM: per scanline, fetches one sprite row and renders it against the incoming pixel stream.
- Sits between display timing/game logic and the sprite ROM: drives `rom_addr`, absorbs the ROM's one-cycle address-register latency, and buffers the row so per-pixel lookup needs no ROM access.
- Output `pixel_on` feeds the colour mux.

Parameters:
- WIDTH, 51, sprite width in pixels = ROM data width
- HEIGHT, 60, sprite height in rows; valid ROM addresses 0..HEIGHT-1
- ADDR_W, 6, ROM address width
- X_W, 11, horizontal coordinate width
- Y_W, 10, vertical coordinate width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- line_start  in  1  one-cycle pulse at start of each scanline
- line_y  in  Y_W  scanline index, sampled with line_start
- sprite_x  in  X_W  sprite left column, sampled with line_start
- sprite_y  in  Y_W  sprite top row, sampled with line_start
- pix_valid  in  1  pixel stream qualifier
- pix_x  in  X_W  current pixel column
- rom_addr  out  ADDR_W  registered row address to sprite ROM
- rom_data  in  WIDTH  ROM row data, valid 2 cycles after rom_addr changes
- pixel_on  out  1  sprite covers pixel (registered)
- pixel_out_valid  out  1  pix_valid delayed 1 cycle
- busy  out  1  row fetch in progress

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; row buffer 0; row_valid 0; latched x 0.
- Row bit mapping: column c (0 = leftmost) is rom_data[WIDTH-1-c]. ROM address r is sprite row r.

FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- On line_start, from any state:
  - Latch sprite_x into x_lat.
  - Compute row = line_y - sprite_y in Y_W+1 bits.
  - Clear row_valid.
  - If line_y >= sprite_y and row < HEIGHT: set rom_addr <= row[ADDR_W-1:0] and go to ISSUE.
  - Otherwise go to (or stay in) IDLE, with rom_addr unchanged.
- ISSUE -> WAIT -> CAPTURE: one cycle each.
  - The ROM registers the address during ISSUE and presents data during CAPTURE.
- CAPTURE: row_buf <= rom_data; row_valid <= 1; go to IDLE.
- busy = 1 in ISSUE, WAIT, CAPTURE.
- A line_start arriving mid-fetch aborts the fetch and restarts per the rule above. The stale row is never captured.
- The ROM must not be read outside HEIGHT rows; rom_addr never exceeds HEIGHT-1.

Pixel path, 1-cycle latency:
- pixel_out_valid <= pix_valid.
- dx = pix_x - x_lat in X_W+1 bits, treated as unsigned with a borrow bit.
- pixel_on <= pix_valid & row_valid & no borrow & dx < WIDTH & row_buf[WIDTH-1-dx].
- dx arithmetic must not wrap. When sprite_x is near 2^X_W-1, pixel columns near 0 must not light.
- Pixels arriving while busy, or after an out-of-range line, give pixel_on = 0.
- sprite_x/sprite_y changes between line_start pulses do not affect the current line.

Test Plan:
1. Assert rst during WAIT -> next cycle: busy=0, rom_addr=0, pixel_on=0, pixel_out_valid=0. A subsequent pix_valid burst gives pixel_on=0 throughout.
2. sprite_x=100, sprite_y=200, line_start with line_y=200 -> rom_addr=0 the next cycle, busy high exactly 3 cycles. Then pix_x=124 gives pixel_on=1 one cycle later; pix_x=123 and pix_x=125 give 0.
3. Same sprite, line_y=215 (row 15 all ones) -> pix_x=99 gives 0, pix_x=100..150 give 1, pix_x=151 gives 0. Each result appears 1 cycle after its pix_x.
4. line_y=199, then line_y=260 -> no fetch, busy stays 0, rom_addr holds its previous value, pixel_on=0 for pix_x 0..2047.
5. line_y=210 fetch, then second line_start with line_y=245 during WAIT -> rom_addr=45, busy re-extends 3 cycles from the second pulse. Row buffer holds row 45: pix_x=100 gives 0, pix_x=101 gives 1, pix_x=149 gives 1, pix_x=150 gives 0.
6. sprite_x=2000, line_y=sprite_y+20 -> pix_x=2000..2047 give 1, pix_x=0..50 give 0 (no wrap-around), pix_valid=0 cycles give pixel_on=0.
